// File: rtl/sm_adder_arbiter_if.sv
// Requester-side bundle for sm_adder_arbiter: operand handshake
// plus the one-hot routed result strobe.
interface sm_adder_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_data;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/sm_adder_arbiter.sv
// Round-robin front end for one shared pipelined sign-magnitude
// adder; tracks the owner of each in-flight op and routes results.
module sm_adder_arbiter #(
  parameter int N    = 32,
  parameter int Q    = 15,
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  sm_adder_arbiter_if.slave req_if,
  output logic [N-1:0]      add_a_o,
  output logic [N-1:0]      add_b_o,
  input  logic [N-1:0]      add_c_i,
  output logic              busy_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NR_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("sm_adder_arbiter: NREQ must be 2..8");
  end
  if (LAT < 0 || LAT > 4) begin : g_bad_lat
    $error("sm_adder_arbiter: LAT must be 0..4");
  end
  if (Q < 0 || Q > N - 1) begin : g_bad_q
    $error("sm_adder_arbiter: Q must fit in the magnitude");
  end

  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_d;
  logic                 gnt;
  logic [PW-1:0]        gidx;
  logic [N-1:0]         add_a_q;
  logic [N-1:0]         add_a_d;
  logic [N-1:0]         add_b_q;
  logic [N-1:0]         add_b_d;
  logic [LAT:0]         trk_v_q;
  logic [LAT:0][PW-1:0] trk_idx_q;
  logic [NREQ-1:0]      rsp_valid_q;
  logic [NREQ-1:0]      rsp_valid_d;
  logic [N-1:0]         rsp_data_q;
  logic [N-1:0]         rsp_data_d;

  // Scan from the highest offset down so the nearest-to-ptr wins.
  always_comb begin : arb
    logic [PW:0] s;
    gnt  = 1'b0;
    gidx = '0;
    s    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr_q} + (PW+1)'(k);
      if (s >= NR_W) s = s - NR_W;
      if (req_if.req_valid[s[PW-1:0]]) begin
        gnt  = 1'b1;
        gidx = s[PW-1:0];
      end
    end
    if (rst) gnt = 1'b0;
  end

  always_comb begin
    req_if.req_ready = '0;
    if (gnt) req_if.req_ready = NREQ'(1) << gidx;
  end

  always_comb begin
    ptr_d   = ptr_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (gnt) begin
      ptr_d   = (gidx == LAST) ? '0 : gidx + PW'(1);
      add_a_d = req_if.req_a[gidx*N +: N];
      add_b_d = req_if.req_b[gidx*N +: N];
    end
  end

  // Zero magnitude is forced to +0 so owners never see -0.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (trk_v_q[LAT]) begin
      rsp_valid_d = NREQ'(1) << trk_idx_q[LAT];
      rsp_data_d  = (add_c_i[N-2:0] == '0) ? '0 : add_c_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      trk_v_q     <= '0;
      trk_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      trk_v_q[0]   <= gnt;
      trk_idx_q[0] <= gidx;
      for (int k = LAT; k > 0; k--) begin
        trk_v_q[k]   <= trk_v_q[k-1];
        trk_idx_q[k] <= trk_idx_q[k-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign add_a_o          = add_a_q;
  assign add_b_o          = add_b_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign busy_o           = (|trk_v_q) | (|rsp_valid_q);
endmodule

// File: tb/tb_sm_adder_arbiter.sv
// Randomised bench for sm_adder_arbiter against a cycle-indexed
// grant/response model, with a behavioural shared adder.
module tb_sm_adder_arbiter;
  localparam int N    = 32;
  localparam int NR   = 4;
  localparam int MAXC = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic [N-1:0] add_c;
  logic         busy;

  sm_adder_arbiter_if #(.N(N), .NREQ(NR)) bus ();

  sm_adder_arbiter #(
    .N(N), .Q(15), .NREQ(NR), .LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_if(bus),
    .add_a_o(add_a),
    .add_b_o(add_b),
    .add_c_i(add_c),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Shared adder: ties return the sign of b, so -0 can appear.
  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0] r;
    if (a[N-1] == b[N-1])
      r = {a[N-1], a[N-2:0] + b[N-2:0]};
    else if (a[N-2:0] > b[N-2:0])
      r = {a[N-1], a[N-2:0] - b[N-2:0]};
    else if (b[N-2:0] > a[N-2:0])
      r = {b[N-1], b[N-2:0] - a[N-2:0]};
    else
      r = {b[N-1], {(N-1){1'b0}}};
    return r;
  endfunction

  always_ff @(posedge clk) add_c <= sm_add(add_a, add_b);

  function automatic logic [N-1:0] ref_sum(input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    longint va, vb, s, m;
    logic [N-1:0] r;
    va = longint'(a[N-2:0]);
    vb = longint'(b[N-2:0]);
    if (a[N-1]) va = -va;
    if (b[N-1]) vb = -vb;
    s = va + vb;
    m = (s < 0) ? -s : s;
    m = m & 64'h7FFF_FFFF;
    if (m == 0) r = '0;
    else        r = {(s < 0), m[N-2:0]};
    return r;
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int           ptr   = 0;
  logic [N-1:0] m_a   = '0;
  logic [N-1:0] m_b   = '0;
  logic [N-1:0] m_rsp = '0;

  bit           ev_v   [MAXC];
  int           ev_idx [MAXC];
  logic [N-1:0] ev_a   [MAXC];
  logic [N-1:0] ev_b   [MAXC];

  task automatic chk(input string tag, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [NR-1:0] v,
                      input logic [NR*N-1:0] a,
                      input logic [NR*N-1:0] b);
    int g;
    int p;
    logic [NR-1:0] er;
    logic [NR-1:0] erv;
    logic eb;
    rst           = r;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    g = -1;
    if (!r) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (ptr + k) % NR;
        if (g < 0 && v[j]) g = j;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    erv = '0;
    p   = cyc - 3;
    if (p >= 0 && ev_v[p]) begin
      erv[ev_idx[p]] = 1'b1;
      m_rsp          = ref_sum(ev_a[p], ev_b[p]);
    end
    eb = 1'b0;
    for (int d = 1; d <= 3; d++)
      if (cyc - d >= 0 && ev_v[cyc-d]) eb = 1'b1;
    chk("req_ready", N'(bus.req_ready), N'(er));
    chk("rsp_valid", N'(bus.rsp_valid), N'(erv));
    chk("rsp_data", bus.rsp_data, m_rsp);
    chk("busy", N'(busy), N'(eb));
    chk("add_a", add_a, m_a);
    chk("add_b", add_b, m_b);
    if (r) begin
      ptr   = 0;
      m_a   = '0;
      m_b   = '0;
      m_rsp = '0;
      for (int d = 1; d <= 2; d++)
        if (cyc - d >= 0) ev_v[cyc-d] = 1'b0;
    end else if (g >= 0) begin
      ev_v[cyc]   = 1'b1;
      ev_idx[cyc] = g;
      ev_a[cyc]   = a[g*N +: N];
      ev_b[cyc]   = b[g*N +: N];
      m_a         = a[g*N +: N];
      m_b         = b[g*N +: N];
      ptr         = (g + 1) % NR;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rnd_ops(output logic [NR*N-1:0] a,
                         output logic [NR*N-1:0] b);
    for (int i = 0; i < NR; i++) begin
      a[i*N +: N] = $urandom;
      if ($urandom_range(0, 7) == 0)
        b[i*N +: N] = a[i*N +: N] ^ 32'h8000_0000;
      else
        b[i*N +: N] = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
  endtask

  task automatic all_valid(input int n);
    logic [NR*N-1:0] a;
    logic [NR*N-1:0] b;
    for (int i = 0; i < n; i++) begin
      rnd_ops(a, b);
      step(1'b0, '1, a, b);
    end
  endtask

  initial begin : main
    logic [NR*N-1:0] a;
    logic [NR*N-1:0] b;
    logic [NR-1:0]   v;
    logic            r;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    @(posedge clk);
    #1;
    cyc = 1;
    step(1'b1, '0, '0, '0);
    step(1'b1, '1, '1, '1);

    a = '0; b = '0;
    a[0 +: N] = 32'h0000_8000;
    b[0 +: N] = 32'h0000_4000;
    step(1'b0, 4'b0001, a, b);
    idle(4);

    a = '0; b = '0;
    a[N +: N] = 32'h0000_4000;
    b[N +: N] = 32'h8000_4000;
    step(1'b0, 4'b0010, a, b);
    idle(4);

    rnd_ops(a, b);
    step(1'b0, 4'b0100, a, b);
    rnd_ops(a, b);
    step(1'b0, 4'b1010, a, b);
    rnd_ops(a, b);
    step(1'b0, 4'b0010, a, b);
    idle(4);

    all_valid(10);
    idle(4);

    all_valid(2);
    step(1'b1, '1, '1, '1);
    idle(5);
    all_valid(2);
    idle(4);

    rnd_ops(a, b);
    step(1'b0, 4'b0011, a, b);
    rnd_ops(a, b);
    step(1'b0, 4'b0010, a, b);
    step(1'b0, 4'b0000, a, b);
    idle(4);

    for (int i = 0; i < 1500; i++) begin
      rnd_ops(a, b);
      r = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 3))
        0:       v = NR'($urandom);
        1:       v = NR'(1) << $urandom_range(0, NR - 1);
        2:       v = '1;
        default: v = '0;
      endcase
      step(r, v, a, b);
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
